rx_mod: RTL and testbench
=========================

// Module: rx_mod
// PURPOSE
//  UART 8N1 receiver, LSB first: idle-high line, start bit 0, 8 data bits, stop bit 1.
//  Oversamples serial input rxd with bclk running at OVS x baud.
//  Samples each bit at its centre and holds the received byte until the consumer acks it.
//  Flags framing errors and overruns.
// PARAMETERS
//  OVS   16   bclk cycles per bit; must be even and >= 4
// PORTS
//  bclk       in   1  oversampling clock, OVS x baud; all logic on posedge bclk
//  rst        in   1  reset, asynchronous, active-high
//  rxd        in   1  serial line, asynchronous to bclk
//  rx_ack     in   1  consumer has taken dout; single-cycle pulse or level
//  dout       out  8  received byte; stable while rx_rdy=1
//  rx_rdy     out  1  byte valid in dout; held until rx_ack
//  frame_err  out  1  byte in dout had stop bit = 0; qualified by rx_rdy
//  overrun    out  1  sticky: a complete frame was dropped while rx_rdy=1
// BEHAVIOUR
//  Reset values:
//   - dout=0, rx_rdy=0, frame_err=0, overrun=0.
//   - Sync flops=1, state=IDLE, counters=0.
//  Input path: rxd passes through a 2-flop synchronizer -> rxs. rxs_d is rxs delayed 1 cycle.
//  Bit counter: cnt, width $clog2(OVS), counts bclk cycles within a bit.
//  Index counter: bit_idx, 3 bits.
//  Shift register: rsr[7:0]. Each data sample does rsr <= {rxs, rsr[7:1]}, so LSB arrives first.
//  States:
//   IDLE:
//    - Start condition is falling edge rxs_d=1 & rxs=0. A line held low out of reset is not a start.
//    - On start: cnt<=0 -> START.
//   START:
//    - At cnt==OVS/2-1 sample rxs.
//    - rxs=1: glitch, -> IDLE, nothing reported.
//    - rxs=0: cnt<=0, bit_idx<=0 -> DATA.
//   DATA:
//    - At cnt==OVS-1 sample rxs into rsr and set cnt<=0. This is the bit centre.
//    - After bit_idx==7 is sampled -> STOP. Otherwise bit_idx++.
//   STOP:
//    - At cnt==OVS-1 sample rxs; the byte is complete.
//    - rxs=1: -> IDLE.
//    - rxs=0: stay in STOP until rxs=1 (break/line-low), then -> IDLE.
//  Byte completion, on the stop-sample cycle; outputs update on the next edge:
//   - If rx_rdy=0 or rx_ack=1 this cycle: dout<=rsr, frame_err<=~rxs, rx_rdy<=1.
//     The new byte wins over a same-cycle ack, and overrun is not set.
//   - Else (rx_rdy=1, no ack): dout and frame_err are unchanged, the new byte is dropped, overrun<=1.
//  Ack handling:
//   - rx_ack with rx_rdy=1 and no completion: rx_rdy<=0, frame_err<=0, overrun<=0.
//   - rx_ack with rx_rdy=0: ignored.
//  Latency: rx_rdy rises 2 + OVS/2 + 9*OVS bclk cycles (+-1) after rxd falls. For OVS=16 that is 154.
//  Reception continues regardless of rx_rdy; the receiver never stalls the line.
//  Reset mid-frame aborts the frame with no output. Reception resumes at the next falling edge after rxs is seen high.
// TESTING (OVS=16; one bit = 16 bclk)
//  1. Send 0xA5: rxd bits 0,1,0,1,0,0,1,0,1,1 -> dout=0xA5, rx_rdy=1 at ~154 cycles, frame_err=0; rx_ack -> rx_rdy=0.
//  2. Glitch: rxd low for 4 cycles, then high -> START aborts at mid-sample; rx_rdy stays 0 for 400 cycles.
//  3. Send 0x3C with stop bit 0 and rxd held low 3 bits -> dout=0x3C, rx_rdy=1, frame_err=1.
//     No new start until rxd returns high; then 0x81 is received correctly after ack.
//  4. Send 0x11 then 0x22 back-to-back, no ack -> dout=0x11, overrun=1.
//     rx_ack -> rx_rdy=0, overrun=0.
//     Repeat with rx_ack on the 0x22 stop-sample cycle -> dout=0x22, rx_rdy=1, overrun=0.
//  5. Assert rst during bit 4 of 0xF0, release with rxd low -> all outputs 0, no byte reported.
//     Next full frame 0x5A is received correctly.
//  6. Stream 0x00..0xFF back-to-back with an ack each byte -> 256 bytes match in order, no frame_err, no overrun.

Source files
------------

// File: rtl/rx_mod.sv
// rx_mod: UART 8N1 receiver (LSB first, idle-high line) oversampled by bclk.
//
// Each bit is sampled at its centre. The received byte is held in dout until
// the consumer acknowledges it. Framing errors and dropped frames are flagged.
//
// Parameters
//   OVS        bclk cycles per bit; must be even and >= 4
//
// Ports
//   bclk       in   oversampling clock (OVS x baud); all logic on posedge
//   rst        in   asynchronous, active-high reset
//   rxd        in   serial line, asynchronous to bclk
//   rx_ack     in   consumer has taken dout (single-cycle pulse or level)
//   dout       out  received byte; stable while rx_rdy=1
//   rx_rdy     out  byte valid in dout; held until rx_ack
//   frame_err  out  byte in dout had stop bit = 0; qualified by rx_rdy
//   overrun    out  sticky: a complete frame was dropped while rx_rdy=1
//   state_o    out  current receiver state, for debug and checkers
//
// Handshake: a byte is transferred when rx_rdy=1 and rx_ack=1 on the same
// posedge. The receiver never waits for the consumer. A byte that completes
// while rx_rdy=1 and no ack is present is dropped and sets overrun.
module rx_mod #(
    parameter int OVS = 16
) (
    input  logic       bclk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] dout,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state_o
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4   // stop bit sampled low; wait for the line to go high
    } state_t;

    // Input synchronizer and edge-detect delay.
    logic       sync1_q, rxs_q, rxs_d_q;

    // vld_q tracks how far real line data has travelled into the
    // synchronizer since reset. armed_q is set once rxs has really been
    // high. Without it, the reset value 1 followed by a line held low
    // would look like a falling edge.
    logic [1:0] vld_q;
    logic       armed_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      rsr_q, rsr_d;
    logic [7:0]      dout_q, dout_d;
    logic            rdy_q, rdy_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            done;

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            rxs_d_q <= 1'b1;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
            rxs_d_q <= rxs_q;
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & rxs_q);
        end
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            rsr_q     <= '0;
            dout_q    <= '0;
            rdy_q     <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            rsr_q     <= rsr_d;
            dout_q    <= dout_d;
            rdy_q     <= rdy_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        rsr_d     = rsr_q;
        dout_d    = dout_q;
        rdy_d     = rdy_q;
        fe_d      = fe_q;
        ovr_d     = ovr_q;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (armed_q && rxs_d_q && !rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid-start-bit check: a line back high here was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    rsr_d = {rxs_q, rsr_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    state_d = rxs_q ? S_IDLE : S_BRK;
                end
            end
            S_BRK: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // A completing byte takes priority over a same-cycle ack.
        if (done) begin
            if (!rdy_q || rx_ack) begin
                dout_d = rsr_q;
                fe_d   = ~rxs_q;
                rdy_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && rdy_q) begin
            rdy_d = 1'b0;
            fe_d  = 1'b0;
            ovr_d = 1'b0;
        end
    end

    assign dout      = dout_q;
    assign rx_rdy    = rdy_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rx_mod.sv
module tb_rx_mod;

    localparam int OVS = 16;
    localparam int LAT_MIN = 2 + OVS / 2 + 9 * OVS - 1;
    localparam int LAT_MAX = 2 + OVS / 2 + 9 * OVS + 1;

    logic       bclk;
    logic       rst;
    logic       rxd;
    logic       rx_ack;
    logic       ack_man;
    logic       ack_auto;
    logic       auto_ack;
    logic [7:0] dout;
    logic       rx_rdy;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    // Expected bytes in arrival order: {frame_err, data}.
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_fe;
    } vec_t;

    assign rx_ack = ack_man | ack_auto;

    rx_mod #(.OVS(OVS)) dut (
        .bclk      (bclk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .dout      (dout),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .state_o   (state_dbg)
    );

    // Clock
    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the line to v for n bclk cycles (called at a negedge).
    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge bclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive(1'b0, OVS);
        for (int i = 0; i < 8; i++) drive(b[i], OVS);
        drive(stop, OVS);
    endtask

    task automatic pulse_ack();
        ack_man = 1'b1;
        @(negedge bclk);
        ack_man = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_rdy"},  32'(rx_rdy), 32'h0);
        check({tag, "_fe"},   32'(frame_err), 32'h0);
        check({tag, "_ovr"},  32'(overrun), 32'h0);
    endtask

    // Consumer: pops the model queue whenever a byte is presented.
    initial begin : consumer
        logic [8:0] e;
        ack_auto = 1'b0;
        forever begin
            @(negedge bclk);
            if (auto_ack && rx_rdy) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_byte", 32'(dout), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_byte", 32'(dout), 32'(e[7:0]));
                    check("stream_fe", 32'(frame_err), 32'(e[8]));
                    check("stream_ovr", 32'(overrun), 32'h0);
                end
                ack_auto = 1'b1;
                @(negedge bclk);
                ack_auto = 1'b0;
            end
        end
    end

    initial begin : main
        vec_t vecs[6];
        int   lat;
        logic seen;
        logic [7:0] b;
        logic stop;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 8'h5A, 1'b1};

        rst      = 1'b1;
        rxd      = 1'b1;
        ack_man  = 1'b0;
        auto_ack = 1'b0;
        repeat (3) @(negedge bclk);
        check_idle_outputs("reset");
        rst = 1'b0;
        drive(1'b1, 2 * OVS);

        // Single 0xA5 frame with latency measurement.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int k = 1; k <= 300; k++) begin
                    @(negedge bclk);
                    if (rx_rdy && lat == 0) lat = k;
                end
            end
        join_any
        wait fork;
        check("latency_in_range", 32'((lat >= LAT_MIN) && (lat <= LAT_MAX)), 32'h1);
        if (!((lat >= LAT_MIN) && (lat <= LAT_MAX)))
            $display("  latency measured %0d cycles", lat);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_fe", 32'(frame_err), 32'h0);
        pulse_ack();
        check("a5_ack_rdy", 32'(rx_rdy), 32'h0);
        drive(1'b1, OVS);

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            check("vec_rdy", 32'(rx_rdy), 32'h1);
            check("vec_dout", 32'(dout), 32'(vecs[i].exp_dout));
            check("vec_fe", 32'(frame_err), 32'(vecs[i].exp_fe));
            check("vec_ovr", 32'(overrun), 32'h0);
            if (!vecs[i].stop) drive(1'b1, OVS);
            pulse_ack();
            check("vec_ack_rdy", 32'(rx_rdy), 32'h0);
            check("vec_ack_fe", 32'(frame_err), 32'h0);
            drive(1'b1, 4);
        end

        // Glitch shorter than half a bit is rejected.
        drive(1'b0, 4);
        seen = 1'b0;
        rxd  = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge bclk);
            if (rx_rdy) seen = 1'b1;
        end
        check("glitch_rdy", 32'(seen), 32'h0);

        // Bad stop bit with the line held low for three bit times.
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 2 * OVS);
        check("brk_rdy", 32'(rx_rdy), 32'h1);
        check("brk_dout", 32'(dout), 32'h3C);
        check("brk_fe", 32'(frame_err), 32'h1);
        check("brk_ovr", 32'(overrun), 32'h0);
        drive(1'b1, OVS);
        pulse_ack();
        check("brk_ack_rdy", 32'(rx_rdy), 32'h0);
        send_frame(8'h81, 1'b1);
        check("after_brk_rdy", 32'(rx_rdy), 32'h1);
        check("after_brk_dout", 32'(dout), 32'h81);
        check("after_brk_fe", 32'(frame_err), 32'h0);
        pulse_ack();

        // Overrun: second byte dropped, first byte kept.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_dout", 32'(dout), 32'h11);
        check("ovr_rdy", 32'(rx_rdy), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_fe", 32'(frame_err), 32'h0);
        pulse_ack();
        check("ovr_ack_rdy", 32'(rx_rdy), 32'h0);
        check("ovr_ack_flag", 32'(overrun), 32'h0);

        // Ack on the stop-sample cycle: the new byte wins, no overrun.
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (2 + OVS / 2 + 9 * OVS) @(negedge bclk);
                ack_man = 1'b1;
                @(negedge bclk);
                ack_man = 1'b0;
            end
        join
        check("ack_race_dout", 32'(dout), 32'h22);
        check("ack_race_rdy", 32'(rx_rdy), 32'h1);
        check("ack_race_ovr", 32'(overrun), 32'h0);
        pulse_ack();

        // Reset in the middle of 0xF0, released with the line low.
        b = 8'hF0;
        drive(1'b0, OVS);
        for (int i = 0; i < 4; i++) drive(b[i], OVS);
        drive(b[4], OVS / 2);
        rst = 1'b1;
        drive(1'b0, 5);
        check_idle_outputs("midrst");
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge bclk);
            if (rx_rdy) seen = 1'b1;
        end
        check("midrst_low_rdy", 32'(seen), 32'h0);
        drive(1'b1, 2 * OVS);
        send_frame(8'h5A, 1'b1);
        check("midrst_5a_rdy", 32'(rx_rdy), 32'h1);
        check("midrst_5a_dout", 32'(dout), 32'h5A);
        check("midrst_5a_fe", 32'(frame_err), 32'h0);
        pulse_ack();

        // Random frames, random stop bits and gaps, against the model.
        auto_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            exp_q.push_back({~stop, b});
            send_frame(b, stop);
            if (!stop) drive(1'b1, OVS);
            drive(1'b1, $urandom_range(0, 20));
        end

        // Back-to-back stream of every byte value.
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({1'b0, 8'(i)});
            send_frame(8'(i), 1'b1);
        end
        drive(1'b1, OVS);

        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge bclk);
        check("stream_drained", 32'(exp_q.size()), 32'h0);
        check("stream_end_ovr", 32'(overrun), 32'h0);
        auto_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
